fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning queue entries (power of two, 2..16).
REQ-002 SHALL have parameter RESET_PC, default 16'h0000, meaning first fetch address after reset.
REQ-003 SHALL have port Clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset_N  input  1  meaning asynchronous active-low reset.
REQ-005 SHALL have port i_readM  output  1  meaning instruction-memory read request.
REQ-006 SHALL have port i_address  output  WORD_SIZE  meaning word address of the outstanding request.
REQ-007 SHALL have port i_data  input  WORD_SIZE  meaning instruction word, valid only when i_ack=1.
REQ-008 SHALL have port i_ack  input  1  meaning one-cycle completion pulse for the outstanding read.
REQ-009 SHALL have port redirect  input  1  meaning flush and restart fetch at redirect_pc.
REQ-010 SHALL have port redirect_pc  input  WORD_SIZE  meaning new fetch address, sampled when redirect=1.
REQ-011 SHALL have port stall_fetch  input  1  meaning no new memory request may be issued (halt).
REQ-012 SHALL have port out_valid  output  1  meaning out_instr/out_pc hold a valid entry for decode.
REQ-013 SHALL have port out_ready  input  1  meaning decode accepts the entry this cycle.
REQ-014 SHALL have ports out_instr and out_pc  output  WORD_SIZE each  meaning head instruction and its address.

Function
REQ-015 SHALL implement FSM states IDLE (no request), REQ (request outstanding), DISCARD (stale request outstanding).
REQ-016 SHALL, in IDLE, move to REQ and assert i_readM with i_address=fetch_pc when stall_fetch=0, redirect=0, and count<DEPTH.
REQ-017 SHALL keep i_readM and i_address stable in REQ and DISCARD until i_ack=1; at most one request outstanding.
REQ-018 SHALL, on i_ack in REQ without redirect, push {fetch_pc, i_data}, increment fetch_pc by 1 modulo 2^16 (16'hFFFF wraps to 0), and return to IDLE.
REQ-019 SHALL, on i_ack in DISCARD, drop i_data, leave fetch_pc unchanged, and return to IDLE.
REQ-020 SHALL pop the head when out_valid=1 and out_ready=1; push and pop in the same cycle leave count unchanged.
REQ-021 SHALL drive out_valid=(count!=0); out_instr/out_pc SHALL be 0 when out_valid=0.
REQ-022 SHALL, on redirect=1, empty the queue (out_valid=0 next cycle), load fetch_pc<=redirect_pc, and go to DISCARD if a request is outstanding without i_ack this cycle, else IDLE; redirect overrides push and pop in that cycle.
REQ-023 SHALL treat redirect coincident with i_ack as a dropped response and go to IDLE.
REQ-024 SHALL never overflow: requests are issued only when count<DEPTH, so an acked word always has a free slot.
REQ-025 SHALL give issue-to-visible latency of 1 cycle after i_ack (entry visible the cycle after the ack edge) without bypass.
REQ-026 SHALL let stall_fetch block only new issues; an outstanding request completes normally.

Reset
REQ-027 SHALL, while Reset_N=0, force state=IDLE, count=0, fetch_pc=RESET_PC, i_readM=0, i_address=0, out_valid=0, out_instr=0, out_pc=0, independent of Clk.
REQ-028 SHALL abandon any outstanding request on reset; memory is reset by the same Reset_N.

Configuration
REQ-029 SHALL, with FETCH_QUEUE_BYPASS_EN defined, present i_data/fetch_pc on outputs with out_valid=1 in the ack cycle when count=0 and no redirect; if out_ready=1 the word is consumed without push.
REQ-030 SHALL, without FETCH_QUEUE_BYPASS_EN, behave per REQ-021/REQ-025 (no combinational path i_data->out_*).

Structure
REQ-031 SHALL take WORD_SIZE from the shared opcodes header; FSM state encodings and DEPTH limits SHALL live in a shared fetch_queue_defs header.
REQ-032 SHALL place entry storage and pointers in one sub-module fq_fifo (circular buffer, wrap at DEPTH, count 0..DEPTH).

Verification
REQ-033 Reset, RESET_PC=0, i_ack 1 cycle after each request, out_ready=1 -> out_pc sequence 0,1,2,3 with matching out_instr.
REQ-034 out_ready=0, DEPTH=4 -> exactly 4 pushes, then i_readM stays 0; one pop -> one new request for address 4.
REQ-035 redirect to 16'h0040 while request outstanding -> i_readM held until i_ack, response dropped, next request at 16'h0040, first out_pc=16'h0040.
REQ-036 RESET_PC=16'hFFFF -> out_pc 16'hFFFF then 16'h0000.
REQ-037 redirect and i_ack same cycle, queue holding 2 entries -> out_valid=0 next cycle, no entry from dropped word.
REQ-038 Reset_N low mid-request with 3 entries queued -> all outputs 0 immediately, fetch restarts at RESET_PC after release.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the instruction fetch queue: word size, FSM state
// encoding, depth limits and small sizing/arithmetic helpers.
package fetch_queue_pkg;

  // Instruction and address word width.
  localparam int WORD_SIZE = 16;

  // Supported queue depth range (power of two within these limits).
  localparam int DEPTH_MIN = 2;
  localparam int DEPTH_MAX = 16;

  // One queue entry is {pc, instr}.
  localparam int ENTRY_W = 2 * WORD_SIZE;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,  // no request outstanding
    ST_REQ     = 2'd1,  // live request outstanding
    ST_DISCARD = 2'd2   // stale request outstanding, response will be dropped
  } fq_state_e;

  // Width of an occupancy counter able to hold 0..depth.
  function automatic int fq_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Width of a pointer into a depth-entry buffer.
  function automatic int fq_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Sequential fetch address; wraps from all-ones to zero.
  function automatic logic [WORD_SIZE-1:0] fq_next_pc(input logic [WORD_SIZE-1:0] pc);
    return pc + {{(WORD_SIZE-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/fetch_queue_fq_fifo.sv
// Circular buffer holding fetched {pc, instr} entries. Pointers wrap at
// DEPTH; count runs 0..DEPTH. Flush empties the buffer in one cycle.
module fq_fifo
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          flush_i,
  input  logic                          push_i,
  input  logic [ENTRY_W-1:0]            push_data_i,
  input  logic                          pop_i,
  output logic [ENTRY_W-1:0]            head_o,
  output logic [fq_cnt_w(DEPTH)-1:0]    count_o
);

  localparam int CW = fq_cnt_w(DEPTH);
  localparam int PW = fq_ptr_w(DEPTH);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]      rd_ptr_q;
  logic [PW-1:0]      wr_ptr_q;
  logic [CW-1:0]      count_q;
  logic [CW-1:0]      count_d;
  logic               push_ok_s;
  logic               pop_ok_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    return (ptr == PTR_LAST) ? {PW{1'b0}} : ptr + {{(PW-1){1'b0}}, 1'b1};
  endfunction

  // Qualify push/pop against occupancy and derive the next count.
  always_comb begin
    pop_ok_s  = pop_i && (count_q != {CW{1'b0}});
    push_ok_s = push_i && ((count_q != CNT_FULL) || pop_ok_s);
    count_d   = count_q;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
      2'b01:   count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
      default: count_d = count_q;
    endcase
  end

  // Storage, pointers and occupancy; flush clears occupancy only.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= {PW{1'b0}};
      wr_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {ENTRY_W{1'b0}};
      end
    end else if (flush_i) begin
      rd_ptr_q <= {PW{1'b0}};
      wr_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      if (push_ok_s) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop_ok_s) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      count_q <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues one memory read at a time, buffers
// returned words with their addresses, and hands them to decode in order.
// A redirect flushes the queue and restarts fetch; a response that was in
// flight at redirect time is dropped.
// Optional: define FETCH_QUEUE_BYPASS_EN to forward an acked word straight
// to the outputs in the ack cycle when the queue is empty.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int                   DEPTH    = 4,
  parameter logic [WORD_SIZE-1:0] RESET_PC = 16'h0000
) (
  input  logic                 Clk,
  input  logic                 Reset_N,
  output logic                 i_readM,
  output logic [WORD_SIZE-1:0] i_address,
  input  logic [WORD_SIZE-1:0] i_data,
  input  logic                 i_ack,
  input  logic                 redirect,
  input  logic [WORD_SIZE-1:0] redirect_pc,
  input  logic                 stall_fetch,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_SIZE-1:0] out_instr,
  output logic [WORD_SIZE-1:0] out_pc
);

  localparam int CW = fq_cnt_w(DEPTH);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  fq_state_e            state_q, state_d;
  logic [WORD_SIZE-1:0] fetch_pc_q, fetch_pc_d;
  logic [WORD_SIZE-1:0] addr_q, addr_d;

  logic                 push_s;
  logic                 pop_s;
  logic                 ack_take_s;
  logic                 fifo_has_s;
  logic [ENTRY_W-1:0]   head_s;
  logic [CW-1:0]        count_s;

  fq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i       (Clk),
    .rst_ni      (Reset_N),
    .flush_i     (redirect),
    .push_i      (push_s),
    .push_data_i ({fetch_pc_q, i_data}),
    .pop_i       (pop_s),
    .head_o      (head_s),
    .count_o     (count_s)
  );

  assign fifo_has_s = (count_s != {CW{1'b0}});
  // A live response is accepted only in REQ and only if no redirect kills it.
  assign ack_take_s = (state_q == ST_REQ) && i_ack && !redirect;

  // FSM state, fetch address and request address registers.
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= {WORD_SIZE{1'b0}};
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
    end
  end

  // Next-state: issue from IDLE when room exists, complete or discard on ack.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    case (state_q)
      ST_IDLE: begin
        if (redirect) begin
          fetch_pc_d = redirect_pc;
          state_d    = ST_IDLE;
        end else if (!stall_fetch && (count_s != CNT_FULL)) begin
          state_d = ST_REQ;
          addr_d  = fetch_pc_q;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (redirect) begin
          fetch_pc_d = redirect_pc;
          state_d    = i_ack ? ST_IDLE : ST_DISCARD;
        end else if (i_ack) begin
          fetch_pc_d = fq_next_pc(fetch_pc_q);
          state_d    = ST_IDLE;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_DISCARD: begin
        if (redirect) begin
          fetch_pc_d = redirect_pc;
          state_d    = i_ack ? ST_IDLE : ST_DISCARD;
        end else if (i_ack) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DISCARD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs and queue control: request lines, push/pop, decode-side view.
  always_comb begin
    i_readM   = (state_q != ST_IDLE);
    i_address = addr_q;
    pop_s     = !redirect && out_ready && fifo_has_s;
`ifdef FETCH_QUEUE_BYPASS_EN
    // An acked word that finds the queue empty and decode ready skips storage.
    push_s = ack_take_s && !(!fifo_has_s && out_ready);
    if (fifo_has_s) begin
      out_valid = 1'b1;
      out_pc    = head_s[ENTRY_W-1:WORD_SIZE];
      out_instr = head_s[WORD_SIZE-1:0];
    end else if (ack_take_s) begin
      out_valid = 1'b1;
      out_pc    = fetch_pc_q;
      out_instr = i_data;
    end else begin
      out_valid = 1'b0;
      out_pc    = {WORD_SIZE{1'b0}};
      out_instr = {WORD_SIZE{1'b0}};
    end
`else
    push_s = ack_take_s;
    if (fifo_has_s) begin
      out_valid = 1'b1;
      out_pc    = head_s[ENTRY_W-1:WORD_SIZE];
      out_instr = head_s[WORD_SIZE-1:0];
    end else begin
      out_valid = 1'b0;
      out_pc    = {WORD_SIZE{1'b0}};
      out_instr = {WORD_SIZE{1'b0}};
    end
`endif
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue (DEPTH=4, RESET_PC=0). The driver plays
// the memory and decode, and keeps a reference model of the expected
// queue contents; a negedge monitor compares the DUT outputs against it.
module tb_fetch_queue;

  logic        Clk = 1'b0;
  logic        Reset_N;
  logic        i_readM;
  logic [15:0] i_address;
  logic [15:0] i_data;
  logic        i_ack;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        stall_fetch;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [15:0] out_pc;

  fetch_queue #(.DEPTH(4), .RESET_PC(16'h0000)) dut (
    .Clk(Clk), .Reset_N(Reset_N), .i_readM(i_readM), .i_address(i_address),
    .i_data(i_data), .i_ack(i_ack), .redirect(redirect), .redirect_pc(redirect_pc),
    .stall_fetch(stall_fetch), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc)
  );

  always #5 Clk = ~Clk;

  typedef struct { logic [15:0] pc; logic [15:0] instr; } ent_t;

  int          errors = 0;
  int          checks = 0;
  ent_t        expq[$];
  logic [15:0] pop_log[$];
  logic [15:0] mpc;
  bit          stale;
  bit          cyc_req;
  bit          mem_busy;
  int          wait_cnt;
  int          lat_min, lat_max;
  int          mode;
  int          pops;
  bit          k_ready, k_stall;
  bit          redir_now;
  logic [15:0] redir_addr;
  bit          redir_on_ack2;
  bit          prev_req, prev_ack, prev_stall, prev_redir;
  logic [15:0] prev_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk_log(input string name, input int idx, input logic [15:0] exp);
    if (idx < pop_log.size()) chk(name, {16'h0, pop_log[idx]}, {16'h0, exp});
    else begin
      checks++; errors++;
      $display("FAIL %s: actual=<no entry popped> expected=%h", name, exp);
    end
  endtask

  task automatic model_reset();
    expq.delete();
    mpc = 16'h0000; stale = 1'b0; cyc_req = 1'b0; mem_busy = 1'b0; wait_cnt = 0;
    i_ack = 1'b0; redirect = 1'b0; i_data = 16'h0; redirect_pc = 16'h0;
  endtask

  // One clock: retire the previous cycle into the model, then drive new inputs.
  task automatic step();
    @(posedge Clk);
    if (redirect) begin
      expq.delete();
      mpc   = redirect_pc;
      stale = cyc_req && !i_ack;
    end else if (i_ack) begin
      if (!stale) begin
        expq.push_back('{pc: mpc, instr: i_data});
        mpc = mpc + 16'd1;
      end
      stale = 1'b0;
    end
    #1;
    cyc_req = i_readM;
    i_ack   = 1'b0;
    if (cyc_req) begin
      if (!mem_busy) begin
        mem_busy = 1'b1;
        wait_cnt = $urandom_range(lat_max, lat_min);
      end
      if (wait_cnt == 0) begin
        i_ack    = 1'b1;
        i_data   = 16'($urandom);
        mem_busy = 1'b0;
      end else wait_cnt--;
    end else mem_busy = 1'b0;
    if (mode == 1) begin
      out_ready   = ($urandom_range(99, 0) < 70);
      stall_fetch = ($urandom_range(99, 0) < 10);
      redirect    = ($urandom_range(99, 0) < 3);
      redirect_pc = ($urandom_range(3, 0) == 0) ? 16'hFFFE : 16'($urandom);
    end else begin
      out_ready   = k_ready;
      stall_fetch = k_stall;
      redirect    = redir_now;
      redirect_pc = redir_addr;
      redir_now   = 1'b0;
      if (redir_on_ack2 && i_ack && expq.size() == 2) begin
        redirect      = 1'b1;
        redirect_pc   = 16'h0100;
        redir_on_ack2 = 1'b0;
      end
    end
  endtask

  // Monitor: compare DUT outputs with the model, then retire any pop.
  always @(negedge Clk) begin
    if (!Reset_N) begin
      prev_req = 1'b0; prev_ack = 1'b0; prev_stall = 1'b0; prev_redir = 1'b0;
    end else begin
      chk("out_valid", {31'h0, out_valid}, {31'h0, (expq.size() != 0)});
      if (out_valid && expq.size() != 0) begin
        chk("out_pc", {16'h0, out_pc}, {16'h0, expq[0].pc});
        chk("out_instr", {16'h0, out_instr}, {16'h0, expq[0].instr});
      end else if (!out_valid) begin
        chk("idle_out_pc", {16'h0, out_pc}, 32'h0);
        chk("idle_out_instr", {16'h0, out_instr}, 32'h0);
      end
      if (i_readM && !stale) begin
        chk("i_address", {16'h0, i_address}, {16'h0, mpc});
        chk("room_at_issue", {31'h0, (expq.size() <= 3)}, 32'h1);
      end
      if (prev_req && !prev_ack) begin
        chk("req_held", {31'h0, i_readM}, 32'h1);
        chk("addr_held", {16'h0, i_address}, {16'h0, prev_addr});
      end
      if (prev_req && prev_ack) chk("idle_after_ack", {31'h0, i_readM}, 32'h0);
      if (i_readM && !prev_req) begin
        chk("issue_not_stalled", {31'h0, prev_stall}, 32'h0);
        chk("issue_not_redirected", {31'h0, prev_redir}, 32'h0);
      end
      if (out_valid && out_ready && !redirect && expq.size() != 0) begin
        pop_log.push_back(expq[0].pc);
        void'(expq.pop_front());
        pops++;
      end
      prev_req = i_readM; prev_ack = i_ack; prev_addr = i_address;
      prev_stall = stall_fetch; prev_redir = redirect;
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_readM"}, {31'h0, i_readM}, 32'h0);
    chk({tag, "_address"}, {16'h0, i_address}, 32'h0);
    chk({tag, "_valid"}, {31'h0, out_valid}, 32'h0);
    chk({tag, "_pc"}, {16'h0, out_pc}, 32'h0);
    chk({tag, "_instr"}, {16'h0, out_instr}, 32'h0);
  endtask

  initial begin
    int mark;
    int n;
    Reset_N = 1'b0; out_ready = 1'b0; stall_fetch = 1'b0;
    mode = 0; k_ready = 1'b1; k_stall = 1'b0; redir_now = 1'b0; redir_addr = 16'h0;
    redir_on_ack2 = 1'b0; pops = 0; lat_min = 1; lat_max = 1;
    model_reset();
    #1;
    check_all_zero("reset");
    @(posedge Clk); @(posedge Clk); #2 Reset_N = 1'b1;

    // In-order fetch from RESET_PC with one-cycle memory.
    repeat (40) step();
    for (int i = 0; i < 4; i++) chk_log("seq_pc", i, 16'(i));

    // Decode stalled: queue fills, then one pop lets one request out.
    k_ready = 1'b0; lat_min = 0; lat_max = 2;
    repeat (40) step();
    chk("full_valid", {31'h0, out_valid}, 32'h1);
    chk("full_no_req", {31'h0, i_readM}, 32'h0);
    k_ready = 1'b1; step(); k_ready = 1'b0;
    n = 0;
    while (!i_readM && n < 10) begin step(); n++; end
    chk("refill_req", {31'h0, i_readM}, 32'h1);
    chk("refill_addr", {16'h0, i_address}, {16'h0, mpc});

    // Redirect while a request is outstanding.
    k_ready = 1'b1; lat_min = 3; lat_max = 3;
    n = 0;
    while (!(cyc_req && mem_busy) && n < 20) begin step(); n++; end
    chk("redir_has_req", {31'h0, i_readM}, 32'h1);
    redir_now = 1'b1; redir_addr = 16'h0040;
    step(); mark = pop_log.size();
    lat_min = 1; lat_max = 1;
    repeat (25) step();
    chk_log("redir_first_pc", mark, 16'h0040);

    // Address wrap through 16'hFFFF.
    redir_now = 1'b1; redir_addr = 16'hFFFE;
    step(); mark = pop_log.size();
    repeat (25) step();
    chk_log("wrap_pc0", mark, 16'hFFFE);
    chk_log("wrap_pc1", mark + 1, 16'hFFFF);
    chk_log("wrap_pc2", mark + 2, 16'h0000);

    // Redirect coinciding with ack while two entries are queued.
    k_ready = 1'b0; redir_now = 1'b1; redir_addr = 16'h0200;
    step();
    redir_on_ack2 = 1'b1;
    n = 0;
    while (redir_on_ack2 && n < 40) begin step(); n++; end
    chk("redir_ack_seen", {31'h0, redir_on_ack2}, 32'h0);
    step();
    chk("redir_ack_flushed", {31'h0, out_valid}, 32'h0);

    // Reset mid-request with three entries queued.
    redir_now = 1'b1; redir_addr = 16'h0300;
    step();
    n = 0;
    while (!(expq.size() == 3 && i_readM) && n < 40) begin step(); n++; end
    chk("pre_reset_req", {31'h0, i_readM}, 32'h1);
    #2 Reset_N = 1'b0;
    #1 check_all_zero("async_reset");
    model_reset();
    @(posedge Clk); @(posedge Clk); #2 Reset_N = 1'b1;
    mark = pop_log.size();
    k_ready = 1'b1;
    repeat (20) step();
    chk_log("restart_pc0", mark, 16'h0000);
    chk_log("restart_pc1", mark + 1, 16'h0001);

    // Randomized traffic.
    mode = 1; lat_min = 0; lat_max = 3;
    repeat (3000) step();
    mode = 0; k_ready = 1'b1; k_stall = 1'b0;
    repeat (40) step();
    chk("progress", {31'h0, (pops > 200)}, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
